sm83_alu_bus_sched: RTL and testbench
=====================================

SM83_ALU_BUS_SCHED -- requirements
Module: sm83_alu_bus_sched

Interface
REQ-001: The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002: Parameter N_REQ, default 4, number of bus requesters (2..8).
REQ-003: Parameter PCH_CYCLES, default 1, minimum consecutive precharge cycles before an evaluate (1..15).
REQ-004: Parameter EVAL_CYCLES, default 1, length of each evaluate window in cycles (1..15).
REQ-005: clk  input  1  system clock.
REQ-006: reset  input  1  synchronous active-high reset.
REQ-007: req  input  N_REQ  per-requester bus request, level, held until done.
REQ-008: pch_n  output  1  active-low precharge enable for the shared precharged ALU bus.
REQ-009: gnt  output  N_REQ  one-hot discharge grant, valid only while pch_n=1.
REQ-010: done  output  1  one-cycle pulse on the last evaluate cycle; bus value is valid to sample.
REQ-011: busy  output  1  high while in EVAL.

Function
REQ-012: The FSM SHALL have states PCH and EVAL; reset state SHALL be PCH.
REQ-013: In PCH: pch_n=0, gnt=0, busy=0; a precharge counter SHALL increment each cycle, saturating at PCH_CYCLES.
REQ-014: PCH->EVAL SHALL occur at the edge where the counter already equals PCH_CYCLES and |req=1; otherwise the FSM SHALL stay in PCH.
REQ-015: On entry to EVAL the round-robin arbiter SHALL latch one winner; gnt SHALL stay constant for all EVAL_CYCLES cycles, even if req changes.
REQ-016: In EVAL: pch_n=1, busy=1, gnt=latched one-hot; an eval counter SHALL count from 1 to EVAL_CYCLES.
REQ-017: done SHALL be 1 exactly in the EVAL cycle where the eval counter equals EVAL_CYCLES; next state SHALL be PCH with the precharge counter cleared to 0.
REQ-018: pch_n=0 and gnt!=0 SHALL never occur in the same cycle, which would be a driver fight on the precharged bus.
REQ-019: Round-robin: search SHALL start at index last_winner+1 modulo N_REQ and pick the first set req bit; after reset last_winner=N_REQ-1, so req[0] has first priority.
REQ-020: last_winner SHALL update only on PCH->EVAL transitions.
REQ-021: A req deasserted before grant SHALL be treated as withdrawn with no side effect; a req deasserted during its own EVAL SHALL NOT shorten the window or suppress done.
REQ-022: A requester still asserting req after its done SHALL re-enter arbitration normally and SHALL lose to any other pending requester.
REQ-023: Minimum turnaround SHALL be PCH_CYCLES+EVAL_CYCLES cycles between successive grants; with the defaults, continuous requests give a grant every second cycle.
REQ-024: Outputs SHALL be registered or decoded from registered state only; no combinational path from req to pch_n, gnt, done or busy.

Reset
REQ-025: Reset asserted in any state, including mid-EVAL, SHALL at the next edge force PCH, pch_n=0, gnt=0, done=0, busy=0, precharge counter=0, eval counter=0 and last_winner=N_REQ-1.
REQ-026: After reset release, the earliest EVAL SHALL begin PCH_CYCLES+1 edges later, so the bus is fully precharged after reset.

Structure
REQ-027: Package sm83_alu_bus_pkg SHALL hold the state enum (PCH, EVAL) and counter-width constant CNT_W=4.
REQ-028: The round-robin pick SHALL be a sub-module sm83_rr_arbiter, parameterised by N_REQ, with inputs req and last_winner and outputs a one-hot winner and its index.
REQ-029: The block SHALL contain no analog or timing (specify) constructs; bus electrical modelling stays in the cell library.

Verification
REQ-030: Reset, then req=4'b0001 held, defaults -> pch_n=0 for 2 edges after reset release, then pch_n=1, gnt=0001, done=1 for 1 cycle, then pch_n=0.
REQ-031: req=4'b1111 held, defaults -> grant order 0001,0010,0100,1000,0001 on alternating cycles; gnt never asserted with pch_n=0.
REQ-032: PCH_CYCLES=3, EVAL_CYCLES=2, req=0100 -> 3 precharge cycles, then gnt=0100 for 2 cycles, with done only on the second.
REQ-033: req[2] dropped in the first EVAL cycle (EVAL_CYCLES=3) -> gnt=0100 held for 3 cycles and done on the third.
REQ-034: reset asserted in the middle of EVAL -> next edge pch_n=0, gnt=0, done=0; the next grant goes to req[0] if it is pending.
REQ-035: An assertion checker SHALL run in all scenarios: $onehot0(gnt), (gnt!=0)->pch_n, done->busy.

Source files
------------

// File: rtl/sm83_alu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm83_alu_bus_pkg
// Brief    : Shared types and constants for the precharged ALU bus scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sm83_alu_bus_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        PCH  = 1'b0,
        EVAL = 1'b1
    } state_t;

endpackage : sm83_alu_bus_pkg
`default_nettype wire

// File: rtl/sm83_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm83_rr_arbiter
// Brief    : Combinational round-robin pick starting after the last winner.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // Walk every requester once, starting one past the previous winner.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_pos      = 0;
        w_sel      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_pos = (int'(last_winner) + off) % N_REQ;
            w_sel = IDX_W'(w_pos);
            if (!w_found && req[w_sel]) begin
                w_found       = 1'b1;
                winner[w_sel] = 1'b1;
                winner_idx    = w_sel;
            end
        end
    end

endmodule : sm83_rr_arbiter
`default_nettype wire

// File: rtl/sm83_alu_bus_sched.sv
`default_nettype none
// ============================================================================
// Module   : sm83_alu_bus_sched
// Brief    : Precharge/evaluate scheduler granting one discharger per window.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_alu_bus_sched
    import sm83_alu_bus_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PCH_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic             pch_n,
    output logic [N_REQ-1:0] gnt,
    output logic             done,
    output logic             busy
);

    localparam int             IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] c_PCH_MAX  = CNT_W'(PCH_CYCLES);
    localparam logic [CNT_W-1:0] c_PCH_WARM = CNT_W'(PCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_EVAL_MAX = CNT_W'(EVAL_CYCLES);
    localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(N_REQ - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_pch_cnt;
    logic [CNT_W-1:0] r_eval_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_last;
    logic             r_warm;

    logic [N_REQ-1:0] w_win;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_pch_ok;
    logic             w_done;

    sm83_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (req),
        .last_winner (r_last),
        .winner      (w_win),
        .winner_idx  (w_win_idx)
    );

    // A cold bus (after reset) needs one extra precharge cycle; once the bus
    // has been evaluated, the done cycle already began its recharge.
    assign w_pch_ok = r_warm ? (r_pch_cnt >= c_PCH_WARM) : (r_pch_cnt == c_PCH_MAX);
    assign w_done   = (r_state == EVAL) && (r_eval_cnt == c_EVAL_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PCH;
            r_pch_cnt  <= '0;
            r_eval_cnt <= '0;
            r_gnt      <= '0;
            r_last     <= c_LAST_RST;
            r_warm     <= 1'b0;
        end else begin
            case (r_state)
                PCH: begin
                    if (w_pch_ok && (|req)) begin
                        r_state    <= EVAL;
                        r_gnt      <= w_win;
                        r_last     <= w_win_idx;
                        r_eval_cnt <= CNT_W'(1);
                        r_warm     <= 1'b1;
                    end else if (r_pch_cnt != c_PCH_MAX) begin
                        r_pch_cnt <= r_pch_cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (w_done) begin
                        r_state    <= PCH;
                        r_gnt      <= '0;
                        r_pch_cnt  <= '0;
                        r_eval_cnt <= '0;
                    end else begin
                        r_eval_cnt <= r_eval_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= PCH;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // Every output comes from registered state, so req never reaches them combinationally.
    assign pch_n = (r_state == EVAL);
    assign busy  = (r_state == EVAL);
    assign gnt   = r_gnt;
    assign done  = w_done;

endmodule : sm83_alu_bus_sched
`default_nettype wire

// File: tb/tb_sm83_alu_bus_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_alu_bus_sched
// Brief    : Directed vector bench for the ALU bus precharge scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_alu_bus_sched;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       pch_n;
        logic [3:0] gnt;
        logic       done;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [3:0] req0 = '0, req1 = '0, req2 = '0;
    logic       pch_n0, pch_n1, pch_n2;
    logic [3:0] gnt0, gnt1, gnt2;
    logic       done0, done1, done2;
    logic       busy0, busy1, busy2;

    int n_pass  = 0;
    int n_total = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sm83_alu_bus_sched #(.N_REQ(4), .PCH_CYCLES(1), .EVAL_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(rst0), .req(req0),
        .pch_n(pch_n0), .gnt(gnt0), .done(done0), .busy(busy0));

    sm83_alu_bus_sched #(.N_REQ(4), .PCH_CYCLES(3), .EVAL_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(rst1), .req(req1),
        .pch_n(pch_n1), .gnt(gnt1), .done(done1), .busy(busy1));

    sm83_alu_bus_sched #(.N_REQ(4), .PCH_CYCLES(1), .EVAL_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(rst2), .req(req2),
        .pch_n(pch_n2), .gnt(gnt2), .done(done2), .busy(busy2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] pack(input logic p, input logic [3:0] g,
                                        input logic d, input logic b);
        return {p, g, d, b};
    endfunction

    // Bus safety invariants, evaluated every cycle on every instance.
    always @(negedge clk) begin
        check("d0_onehot", 32'($onehot0(gnt0)), 32'd1);
        check("d0_gnt_pch", 32'((gnt0 == 4'd0) || pch_n0), 32'd1);
        check("d0_done_busy", 32'(!done0 || busy0), 32'd1);
        check("d1_onehot", 32'($onehot0(gnt1)), 32'd1);
        check("d1_gnt_pch", 32'((gnt1 == 4'd0) || pch_n1), 32'd1);
        check("d1_done_busy", 32'(!done1 || busy1), 32'd1);
        check("d2_onehot", 32'($onehot0(gnt2)), 32'd1);
        check("d2_gnt_pch", 32'((gnt2 == 4'd0) || pch_n2), 32'd1);
        check("d2_done_busy", 32'(!done2 || busy2), 32'd1);
    end

    initial begin
        // rst, req, pch_n, gnt, done, busy  (defaults: PCH=1, EVAL=1)
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            rst0 = tbl[i].rst;
            req0 = tbl[i].req;
            cyc();
            check($sformatf("d0_vec%0d", i), 32'(pack(pch_n0, gnt0, done0, busy0)),
                  32'(pack(tbl[i].pch_n, tbl[i].gnt, tbl[i].done, tbl[i].busy)));
        end

        // PCH_CYCLES=3, EVAL_CYCLES=2, single requester 2
        rst1 = 1'b1;
        cyc();
        check("d1_reset", 32'(pack(pch_n1, gnt1, done1, busy1)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        rst1 = 1'b0;
        req1 = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("d1_cold_pch%0d", k), 32'(pack(pch_n1, gnt1, done1, busy1)),
                  32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        end
        cyc();
        check("d1_eval1", 32'(pack(pch_n1, gnt1, done1, busy1)), 32'(pack(1'b1, 4'b0100, 1'b0, 1'b1)));
        cyc();
        check("d1_eval2", 32'(pack(pch_n1, gnt1, done1, busy1)), 32'(pack(1'b1, 4'b0100, 1'b1, 1'b1)));
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("d1_warm_pch%0d", k), 32'(pack(pch_n1, gnt1, done1, busy1)),
                  32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        end
        cyc();
        check("d1_regrant", 32'(pack(pch_n1, gnt1, done1, busy1)), 32'(pack(1'b1, 4'b0100, 1'b0, 1'b1)));

        // EVAL_CYCLES=3: withdrawn req mid-window, then reset mid-window
        rst2 = 1'b1;
        cyc();
        check("d2_reset", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        rst2 = 1'b0;
        req2 = 4'b0100;
        cyc();
        check("d2_pch", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        cyc();
        check("d2_eval1", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b1, 4'b0100, 1'b0, 1'b1)));
        req2 = 4'b0000;
        cyc();
        check("d2_eval2_dropped", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b1, 4'b0100, 1'b0, 1'b1)));
        cyc();
        check("d2_eval3_done", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b1, 4'b0100, 1'b1, 1'b1)));
        cyc();
        check("d2_back_pch", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        req2 = 4'b1001;
        cyc();
        check("d2_rr_after2", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b1, 4'b1000, 1'b0, 1'b1)));
        rst2 = 1'b1;
        cyc();
        check("d2_mid_reset", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        rst2 = 1'b0;
        cyc();
        check("d2_post_rst_pch", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b0, 4'b0000, 1'b0, 1'b0)));
        cyc();
        check("d2_post_rst_gnt0", 32'(pack(pch_n2, gnt2, done2, busy2)), 32'(pack(1'b1, 4'b0001, 1'b0, 1'b1)));

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sm83_alu_bus_sched
`default_nettype wire
